// File: rtl/reg_file_2r1w_if.sv
// Bus interface for reg_file_2r1w: one write port, two registered read
// ports and the bulk-clear request/busy/done handshake.
interface reg_file_2r1w_if #(
   parameter int W_WIDTH = 32,
   parameter int ADDR_W  = 3
);
   logic               wr_en_i;
   logic [ADDR_W-1:0]  wr_addr_i;
   logic [W_WIDTH-1:0] wr_data_i;
   logic               wr_ready_o;
   logic [ADDR_W-1:0]  rd_addr_a_i;
   logic [W_WIDTH-1:0] rd_data_a_o;
   logic [ADDR_W-1:0]  rd_addr_b_i;
   logic [W_WIDTH-1:0] rd_data_b_o;
   logic               clr_req_i;
   logic               clr_busy_o;
   logic               clr_done_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, rd_addr_a_i, rd_addr_b_i, clr_req_i,
      input  wr_ready_o, rd_data_a_o, rd_data_b_o, clr_busy_o, clr_done_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_a_i, rd_addr_b_i, clr_req_i,
      output wr_ready_o, rd_data_a_o, rd_data_b_o, clr_busy_o, clr_done_o
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised register file, one write port, two registered read ports with
// write-first bypass, and a one-register-per-cycle bulk-clear sweep.
// Optional build macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | normal operation, writes accepted, clr_req_i sampled
// S_CLEAR | sweeping reg[ptr] to zero each cycle, writes refused
// S_DONE  | one-cycle completion pulse, writes accepted, req ignored
module reg_file_2r1w #(
   parameter int W_WIDTH = 32,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3
) (
   input logic           CLK,
   input logic           RST,
   reg_file_2r1w_if.slave bus
);

   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
      $error("reg_file_2r1w: DEPTH must be within 2..256");
   end
   if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
      $error("reg_file_2r1w: ADDR_W too narrow for DEPTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [W_WIDTH-1:0] mem_q [DEPTH];
   logic [W_WIDTH-1:0] mem_d [DEPTH];
   logic [W_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
   logic [W_WIDTH-1:0] rd_data_b_q, rd_data_b_d;

   logic wr_ready;
   logic wr_acc;

   assign wr_ready = (state_q != S_CLEAR);

   // Write acceptance: ready, in range, and (optionally) not the zero register.
   always_comb begin
      wr_acc = bus.wr_en_i && wr_ready && ({1'b0, bus.wr_addr_i} < DEPTH_A);
`ifdef REG_FILE_ZERO_REG_EN
      if (bus.wr_addr_i == '0) wr_acc = 1'b0;
`endif
   end

   // Clear sequencer next state and pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.clr_req_i) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end
         end
         S_CLEAR: begin
            if (ptr_q == LAST_PTR) begin
               state_d = S_DONE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next storage contents; reads take this so both bypass cases fall out.
   always_comb begin
      mem_d = mem_q;
      if (wr_acc) mem_d[bus.wr_addr_i[IDX_W-1:0]] = bus.wr_data_i;
      if (state_q == S_CLEAR) mem_d[ptr_q[IDX_W-1:0]] = '0;
`ifdef REG_FILE_ZERO_REG_EN
      mem_d[0] = '0;
`endif
   end

   // Read port data, zero for out-of-range addresses.
   always_comb begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      if ({1'b0, bus.rd_addr_a_i} < DEPTH_A) rd_data_a_d = mem_d[bus.rd_addr_a_i[IDX_W-1:0]];
      if ({1'b0, bus.rd_addr_b_i} < DEPTH_A) rd_data_b_d = mem_d[bus.rd_addr_b_i[IDX_W-1:0]];
   end

   // State, pointer, storage and read registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.wr_ready_o  = wr_ready;
   assign bus.clr_busy_o  = (state_q == S_CLEAR);
   assign bus.clr_done_o  = (state_q == S_DONE);
   assign bus.rd_data_a_o = rd_data_a_q;
   assign bus.rd_data_b_o = rd_data_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w against a cycle-level array model.
module tb_reg_file_2r1w;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;
   localparam int W      = 32;
`ifdef REG_FILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic clk;
   logic rst_n;

   reg_file_2r1w_if #(.W_WIDTH(W), .ADDR_W(ADDR_W)) ifc ();

   reg_file_2r1w #(.W_WIDTH(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: contents, sweep position (-1 when not sweeping), done flag.
   logic [31:0] m_mem [DEPTH];
   int          m_sweep;
   bit          m_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_sweep = -1;
      m_done  = 1'b0;
   endtask

   // One clock: drive inputs (caller is at a falling edge), advance model, check.
   task automatic step(input bit we, input int wa, input logic [31:0] wd,
                       input int ra, input int rb, input bit cr);
      logic [31:0] ea, eb;
      bit rdy;
      ifc.wr_en_i     = we;
      ifc.wr_addr_i   = ADDR_W'(wa);
      ifc.wr_data_i   = wd;
      ifc.rd_addr_a_i = ADDR_W'(ra);
      ifc.rd_addr_b_i = ADDR_W'(rb);
      ifc.clr_req_i   = cr;
      @(posedge clk);
      rdy = (m_sweep < 0);
      if (rdy && we && wa < DEPTH && !(ZERO_REG && wa == 0)) m_mem[wa] = wd;
      if (m_sweep >= 0) m_mem[m_sweep] = '0;
      ea = (ra < DEPTH) ? m_mem[ra] : 32'h0;
      eb = (rb < DEPTH) ? m_mem[rb] : 32'h0;
      if (m_sweep >= 0) begin
         if (m_sweep == DEPTH - 1) begin
            m_sweep = -1;
            m_done  = 1'b1;
         end else begin
            m_sweep++;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (cr) begin
         m_sweep = 0;
      end
      @(negedge clk);
      chk("rd_a",  ifc.rd_data_a_o, ea);
      chk("rd_b",  ifc.rd_data_b_o, eb);
      chk("busy",  32'(ifc.clr_busy_o), 32'(m_sweep >= 0));
      chk("done",  32'(ifc.clr_done_o), 32'(m_done));
      chk("ready", 32'(ifc.wr_ready_o), 32'(m_sweep < 0));
   endtask

   task automatic idle_step(input int ra, input int rb);
      step(1'b0, 0, 32'h0, ra, rb, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_a"},  ifc.rd_data_a_o, 32'h0);
      chk({tag, "_rd_b"},  ifc.rd_data_b_o, 32'h0);
      chk({tag, "_busy"},  32'(ifc.clr_busy_o), 32'h0);
      chk({tag, "_done"},  32'(ifc.clr_done_o), 32'h0);
      chk({tag, "_ready"}, 32'(ifc.wr_ready_o), 32'h1);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      ifc.wr_en_i = 1'b0; ifc.wr_addr_i = '0; ifc.wr_data_i = '0;
      ifc.rd_addr_a_i = '0; ifc.rd_addr_b_i = '0; ifc.clr_req_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // All addresses read zero after reset, including out-of-range ones.
      for (int i = 0; i < 10; i++) idle_step(i, 9 - i);

      // Plain write then read on both ports.
      step(1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0);
      idle_step(5, 5);

      // Prior value, then write-first bypass on the same edge.
      idle_step(0, 3);
      step(1'b1, 3, 32'h12345678, 3, 0, 1'b0);
      idle_step(3, 3);

      // Fill, then sweep with a dropped mid-sweep write to addr 2.
      for (int i = 0; i < DEPTH; i++) step(1'b1, i, 32'h11 * (i + 1), i, 0, 1'b0);
      step(1'b0, 0, 32'h0, 1, 2, 1'b1);
      busy_cnt = 0;
      done_cnt = 0;
      if (ifc.clr_busy_o) busy_cnt++;
      for (int i = 0; i < 12; i++) begin
         step(i == 3, 2, 32'hCAFEF00D, i % DEPTH, 7 - (i % DEPTH), 1'b0);
         if (ifc.clr_busy_o) busy_cnt++;
         if (ifc.clr_done_o) done_cnt++;
      end
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
      chk("sweep_done_pulses", 32'(done_cnt), 32'h1);
      for (int i = 0; i < DEPTH; i++) idle_step(i, 2);

      // Out-of-range write and read.
      step(1'b1, 8, 32'hA5A5A5A5, 8, 0, 1'b0);
      idle_step(8, 15);

      // Register 0 write (hardwired zero only with the option built in).
      step(1'b1, 0, 32'hFFFFFFFF, 0, 1, 1'b0);
      step(1'b1, 1, 32'h0BADF00D, 0, 1, 1'b0);
      idle_step(0, 1);

      // Held request: sweeps back to back with one idle cycle; write on req edge.
      step(1'b1, 6, 32'h66666666, 6, 0, 1'b1);
      for (int i = 0; i < 2 * DEPTH + 6; i++) step(1'b1, i % DEPTH, $urandom, i % DEPTH, 6, 1'b1);
      idle_step(6, 0);

      // Reset in the middle of a sweep.
      for (int i = 0; i < DEPTH; i++) step(1'b1, i, $urandom, 0, 0, 1'b0);
      step(1'b0, 0, 32'h0, 0, 0, 1'b1);
      idle_step(1, 2);
      idle_step(3, 4);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midsweep_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) idle_step(i, DEPTH - 1 - i);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         int wa;
         wa = $urandom_range(0, 9);
         step($urandom_range(0, 1) == 1, wa, $urandom,
              ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised multi-port register file; successor to the fixed 8 x 32-bit register set.
- Generalises width and depth, and merges the internal address decode into the block.
- Adds two registered read ports with write-first bypass, plus a sequenced bulk-clear engine with a busy/done handshake.
- Sits between the instruction decode/writeback stages and the ALU operand muxes.

Parameters:
- W_WIDTH, 32, data width of each register in bits.
- DEPTH, 8, number of registers; range 2..256.
- ADDR_W, 3, address width; 2^ADDR_W >= DEPTH is required, and an elaboration-time check fails otherwise.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- wr_en_i  input  1  write request.
- wr_addr_i  input  ADDR_W  write address.
- wr_data_i  input  W_WIDTH  write data.
- wr_ready_o  output  1  high when a write will be accepted; low while clearing.
- rd_addr_a_i  input  ADDR_W  read port A address.
- rd_data_a_o  output  W_WIDTH  read port A data, registered.
- rd_addr_b_i  input  ADDR_W  read port B address.
- rd_data_b_o  output  W_WIDTH  read port B data, registered.
- clr_req_i  input  1  bulk-clear request; level, sampled in IDLE only.
- clr_busy_o  output  1  high while the clear sweep is in progress.
- clr_done_o  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (RST=0, async):
  - All registers = 0; rd_data_a_o = rd_data_b_o = 0.
  - FSM = IDLE, clear pointer = 0.
  - clr_busy_o = 0, clr_done_o = 0, wr_ready_o = 1.
  - Reset asserted mid-sweep aborts the sweep to the same state.
- Write:
  - reg[wr_addr_i] <= wr_data_i at the edge where wr_en_i=1, wr_ready_o=1 and wr_addr_i < DEPTH.
  - wr_addr_i >= DEPTH: write silently dropped.
  - wr_en_i while wr_ready_o=0: write dropped; no buffering, the requester retries.
- Read:
  - 1-cycle latency: the address sampled at edge k is presented on rd_data_x_o after edge k.
  - Each port is independent; both ports may address the same register.
  - Address >= DEPTH returns 0.
- Bypass (write-first):
  - If the write accepted at edge k targets the same address a port samples at edge k, that port outputs the new wr_data_i after edge k, not the old contents.
  - Clear-engine writes bypass the same way, so the port returns 0.
- Clear FSM, states IDLE / CLEAR / DONE:
  - IDLE: clr_req_i=1 at an edge -> CLEAR, pointer = 0. A write accepted at that same edge still completes, and the sweep later zeroes it.
  - CLEAR:
    - Each edge sets reg[pointer] = 0 and pointer++.
    - When pointer == DEPTH-1 at an edge, that register is zeroed and the FSM moves to DONE.
    - clr_busy_o=1 and wr_ready_o=0 for exactly DEPTH cycles.
  - DONE: clr_done_o=1 for one cycle, busy=0, wr_ready_o=1; next edge -> IDLE.
  - clr_req_i is ignored in CLEAR and DONE. A request held high re-triggers from IDLE: one idle cycle between sweeps.
- Reads are permitted during a sweep. A register not yet swept returns its old value; a swept register returns 0.
- No combinational path from any input to any output. wr_ready_o and clr_busy_o are derived from FSM state only.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to address 0 are accepted (wr_ready_o unaffected) but have no effect.
  - Reads of address 0 always return 0, including the bypass case.
  - The sweep still covers DEPTH cycles.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
- Reset then read all addresses on both ports -> every rd_data = 0; wr_ready_o=1, clr_busy_o=0.
- Write 0xDEADBEEF to addr 5, next cycle read A=5, B=5 -> both ports output 0xDEADBEEF one cycle later.
- Same edge: write 0x12345678 to addr 3 and read A=3 -> rd_data_a_o = 0x12345678 after that edge (bypass). Read B=3 one cycle earlier returned the prior value 0.
- Fill all 8 registers with 0x11*(i+1), pulse clr_req_i -> clr_busy_o high exactly 8 cycles. Then clr_done_o one-cycle pulse, then all reads = 0. A write to addr 2 issued mid-sweep is dropped: addr 2 reads 0.
- Write/read addr 8 with DEPTH=8, ADDR_W=4 -> write ignored, read returns 0. Assert RST mid-sweep -> outputs zero immediately; FSM in IDLE after release.
- With REG_FILE_ZERO_REG_EN: write 0xFFFFFFFF to addr 0 -> reads of addr 0 (normal and bypass) return 0; addr 1 behaves normally.
